// File: rtl/io_pkg.sv
// Shared types for the I/O channel unit: channel numbers, channel words and
// the {channel, data} event that is queued towards the peripheral.
package io_pkg;

   localparam int unsigned IO_NUM_CHAN = 32;
   localparam int unsigned IO_WORD_W   = 15;

   typedef logic [4:0]           chan_sel_t;
   typedef logic [IO_WORD_W-1:0] io_word_t;

   typedef struct packed {
      chan_sel_t chan;
      io_word_t  data;
   } io_event_t;

   // Odd parity over the whole event: the result makes the total count of ones odd.
   function automatic logic odd_parity(input io_event_t ev);
      return ~^ev;
   endfunction

endpackage

// File: rtl/io_event_fifo.sv
// Event queue between the core write port and the peripheral handshake.
// Circular buffer with a separate occupancy counter so "full" and "empty"
// never need pointer-comparison tricks. A push into a full queue is only
// accepted when a pop frees a slot in the same cycle; otherwise it is
// dropped and reported on the drop output.
module io_event_fifo
   import io_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  io_event_t        push_data,
   input  logic             pop,
   output io_event_t        head,
   output logic             valid,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             drop
);

   io_event_t        mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign valid   = (count_q != '0);
   assign full    = (count_q == CNT_W'(DEPTH));
   // A pop on an empty queue is meaningless and is ignored.
   assign do_pop  = pop & valid;
   // When full, only a simultaneous pop makes room for the new entry.
   assign do_push = push & (~full | do_pop);
   assign drop    = push & full & ~do_pop;
   assign count   = count_q;
   // Present zeros while empty so the peripheral-facing bus is quiet.
   assign head    = valid ? mem[rd_ptr_q] : '0;

   // Next-state for pointers and occupancy; pointers wrap naturally at DEPTH.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
         count_d = count_q + 1'b1;
      end else if (do_pop && !do_push) begin
         count_d = count_q - 1'b1;
      end
   end

   // Pointer and occupancy state; reset discards every queued entry.
   always_ff @(posedge clock) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents need no reset because head is gated by valid.
   always_ff @(posedge clock) begin
      if (do_push && !reset) begin
         mem[wr_ptr_q] <= push_data;
      end
   end

endmodule

// File: rtl/io_channel_unit.sv
// I/O channel unit: 32 channel registers written by the core (writeback
// stage) and by a peripheral, a zero-latency read port for the decode stage
// with write bypass, and an event queue that forwards every core write to an
// output channel to the peripheral over valid/ready.
// Optional build macro: IO_CHAN_PARITY_EN adds odd parity on the event bus;
// without it out_parity is tied low.
module io_channel_unit
   import io_pkg::*;
#(
   parameter logic [31:0] OUT_MASK    = 32'hFFFF_0000,
   parameter logic [31:0] IN_MASK     = 32'h0000_FFFE,
   parameter int unsigned FIFO_DEPTH  = 8,
   parameter chan_sel_t   STATUS_CHAN = 5'd31
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        IO_write_en,
   input  logic [4:0]  IO_write_sel,
   input  logic [14:0] IO_write_data,
   input  logic [4:0]  IO_read_sel,
   output logic [14:0] IO_read_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [4:0]  out_chan,
   output logic [14:0] out_data,
   output logic        out_parity,
   input  logic        in_valid,
   input  logic [4:0]  in_chan,
   input  logic [14:0] in_data,
   output logic        overflow
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

   io_word_t         chan_q [IO_NUM_CHAN];
   logic             overflow_q, overflow_d;
   logic             core_wr;
   logic             periph_wr;
   logic             status_clr;
   io_event_t        push_ev;
   io_event_t        head;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_drop;
   logic             unused_fifo_full;
   io_word_t         status_word;

   // The status channel is read-only for both sources; a core write to it
   // only clears the sticky overflow flag and never becomes an event.
   assign core_wr    = IO_write_en & OUT_MASK[IO_write_sel] & (IO_write_sel != STATUS_CHAN);
   assign status_clr = IO_write_en & (IO_write_sel == STATUS_CHAN);
   assign periph_wr  = in_valid & IN_MASK[in_chan] & (in_chan != STATUS_CHAN);

   assign push_ev.chan = IO_write_sel;
   assign push_ev.data = IO_write_data;

   io_event_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (core_wr),
      .push_data (push_ev),
      .pop       (out_ready),
      .head      (head),
      .valid     (out_valid),
      .count     (fifo_count),
      .full      (unused_fifo_full),
      .drop      (fifo_drop)
   );

   assign out_chan = head.chan;
   assign out_data = head.data;

`ifdef IO_CHAN_PARITY_EN
   // Parity follows the registered head entry; quiet bus while empty.
   assign out_parity = out_valid & odd_parity(head);
`else
   assign out_parity = 1'b0;
`endif

   // Channel registers; the core write is applied last so it wins a same-channel collision.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned i = 0; i < IO_NUM_CHAN; i++) begin
            chan_q[i] <= '0;
         end
      end else begin
         if (periph_wr) begin
            chan_q[in_chan] <= in_data;
         end
         if (core_wr) begin
            chan_q[IO_write_sel] <= IO_write_data;
         end
      end
   end

   // Sticky overflow: a drop in the same cycle as a clear keeps the flag set.
   always_comb begin
      overflow_d = overflow_q;
      if (fifo_drop) begin
         overflow_d = 1'b1;
      end else if (status_clr) begin
         overflow_d = 1'b0;
      end
   end

   // Overflow flag register.
   always_ff @(posedge clock) begin
      if (reset) begin
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= overflow_d;
      end
   end

   assign overflow    = overflow_q;
   assign status_word = {overflow_q, {(IO_WORD_W - 1 - CNT_W){1'b0}}, fifo_count};

   // Decode-stage read with bypass of this cycle's writes (core before peripheral).
   always_comb begin
      IO_read_data = chan_q[IO_read_sel];
      if (IO_read_sel == STATUS_CHAN) begin
         IO_read_data = status_word;
      end else if (core_wr && (IO_write_sel == IO_read_sel)) begin
         IO_read_data = IO_write_data;
      end else if (periph_wr && (in_chan == IO_read_sel)) begin
         IO_read_data = in_data;
      end
   end

endmodule

// File: tb/tb_io_channel_unit.sv
// Self-checking bench for io_channel_unit: directed scenarios plus a random
// run compared against a queue-based behavioural model.
module tb_io_channel_unit;

   // Channels 0 and 1 are made core-writable so parity heads on ch0/ch1 and
   // the core/peripheral overlap on ch1 can be exercised.
   localparam logic [31:0] OUT_MASK_TB = 32'hFFFF_0003;
   localparam logic [31:0] IN_MASK_TB  = 32'h0000_FFFE;
   localparam int          DEPTH       = 8;
   localparam logic [4:0]  STAT        = 5'd31;

   logic        clock = 1'b0;
   logic        reset;
   logic        IO_write_en;
   logic [4:0]  IO_write_sel;
   logic [14:0] IO_write_data;
   logic [4:0]  IO_read_sel;
   logic [14:0] IO_read_data;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_chan;
   logic [14:0] out_data;
   logic        out_parity;
   logic        in_valid;
   logic [4:0]  in_chan;
   logic [14:0] in_data;
   logic        overflow;

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural model state.
   logic [14:0] m_regs [32];
   logic [19:0] m_q [$];
   logic        m_ovf;

   always #5 clock = ~clock;

   io_channel_unit #(
      .OUT_MASK    (OUT_MASK_TB),
      .IN_MASK     (IN_MASK_TB),
      .FIFO_DEPTH  (DEPTH),
      .STATUS_CHAN (STAT)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .IO_write_en   (IO_write_en),
      .IO_write_sel  (IO_write_sel),
      .IO_write_data (IO_write_data),
      .IO_read_sel   (IO_read_sel),
      .IO_read_data  (IO_read_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_chan      (out_chan),
      .out_data      (out_data),
      .out_parity    (out_parity),
      .in_valid      (in_valid),
      .in_chan       (in_chan),
      .in_data       (in_data),
      .overflow      (overflow)
   );

   function automatic bit core_ok(input logic [4:0] c);
      return OUT_MASK_TB[c] && (c != STAT);
   endfunction

   function automatic bit in_ok(input logic [4:0] c);
      return IN_MASK_TB[c] && (c != STAT);
   endfunction

   function automatic logic [14:0] exp_read();
      logic [3:0] cnt;
      cnt = 4'(m_q.size());
      if (IO_read_sel == STAT) return {m_ovf, 10'b0, cnt};
      if (IO_write_en && IO_write_sel == IO_read_sel && core_ok(IO_write_sel))
         return IO_write_data;
      if (in_valid && in_chan == IO_read_sel && in_ok(in_chan)) return in_data;
      return m_regs[IO_read_sel];
   endfunction

   function automatic logic exp_parity();
      if (m_q.size() == 0) return 1'b0;
`ifdef IO_CHAN_PARITY_EN
      return ~^m_q[0];
`else
      return 1'b0;
`endif
   endfunction

   // Advance the model by one clock using the inputs currently applied.
   task automatic model_clock();
      bit          pop;
      bit          push;
      logic [19:0] tmp;
      if (reset) begin
         foreach (m_regs[i]) m_regs[i] = '0;
         m_q.delete();
         m_ovf = 1'b0;
         return;
      end
      pop  = out_ready && (m_q.size() > 0);
      push = IO_write_en && core_ok(IO_write_sel);
      if (in_valid && in_ok(in_chan)) m_regs[in_chan] = in_data;
      if (push) m_regs[IO_write_sel] = IO_write_data;
      if (push && m_q.size() == DEPTH && !pop) begin
         m_ovf = 1'b1;
      end else begin
         if (pop) tmp = m_q.pop_front();
         if (push) m_q.push_back({IO_write_sel, IO_write_data});
         if (IO_write_en && IO_write_sel == STAT) m_ovf = 1'b0;
      end
   endtask

   task automatic tick();
      @(posedge clock);
      model_clock();
      @(negedge clock);
   endtask

   task automatic idle();
      IO_write_en   = 1'b0;
      IO_write_sel  = '0;
      IO_write_data = '0;
      in_valid      = 1'b0;
      in_chan       = '0;
      in_data       = '0;
   endtask

   task automatic drain();
      idle();
      out_ready = 1'b1;
      repeat (DEPTH + 2) tick();
      out_ready = 1'b0;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL drain_empty: out_valid=%b required 0", out_valid);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      out_ready = 1'b0;
      IO_read_sel = '0;
      idle();
      tick();
      tick();
      reset = 1'b0;
      for (int i = 0; i < 32; i++) begin
         IO_read_sel = 5'(i);
         #1;
         n_cmp++;
         if (IO_read_data !== 15'h0000) begin
            n_bad++;
            $display("FAIL reset_read ch%0d: got %h required 0000", i, IO_read_data);
         end
         tick();
      end
      #1;
      n_cmp++;
      if ({out_valid, out_chan, out_data, out_parity, overflow} !== 23'd0) begin
         n_bad++;
         $display("FAIL reset_outputs: valid=%b chan=%0d data=%h par=%b ovf=%b required all 0",
                  out_valid, out_chan, out_data, out_parity, overflow);
      end
   endtask

   task automatic test_bypass();
      out_ready     = 1'b0;
      IO_write_en   = 1'b1;
      IO_write_sel  = 5'd20;
      IO_write_data = 15'o12345;
      IO_read_sel   = 5'd20;
      #1;
      n_cmp++;
      if (IO_read_data !== 15'o12345) begin
         n_bad++;
         $display("FAIL bypass_read: got %o required 12345", IO_read_data);
      end
      tick();
      idle();
      #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_chan !== 5'd20 || out_data !== 15'o12345) begin
         n_bad++;
         $display("FAIL first_event: valid=%b chan=%0d data=%o required 1/20/12345",
                  out_valid, out_chan, out_data);
      end
      IO_read_sel = STAT;
      #1;
      n_cmp++;
      if (IO_read_data !== 15'h0001) begin
         n_bad++;
         $display("FAIL status_count1: got %h required 0001", IO_read_data);
      end
   endtask

   task automatic test_overflow();
      drain();
      for (int k = 1; k <= 9; k++) begin
         IO_write_en   = 1'b1;
         IO_write_sel  = 5'd17;
         IO_write_data = 15'(k);
         tick();
      end
      idle();
      IO_read_sel = STAT;
      #1;
      n_cmp++;
      if (overflow !== 1'b1 || IO_read_data !== 15'h4008) begin
         n_bad++;
         $display("FAIL overflow_set: ovf=%b status=%h required 1/4008", overflow, IO_read_data);
      end
      n_cmp++;
      if (out_chan !== 5'd17 || out_data !== 15'd1) begin
         n_bad++;
         $display("FAIL full_head: chan=%0d data=%h required 17/0001", out_chan, out_data);
      end
      IO_write_en   = 1'b1;
      IO_write_sel  = STAT;
      IO_write_data = 15'h7FFF;
      tick();
      idle();
      #1;
      n_cmp++;
      if (overflow !== 1'b0 || IO_read_data !== 15'h0008) begin
         n_bad++;
         $display("FAIL overflow_clear: ovf=%b status=%h required 0/0008", overflow, IO_read_data);
      end
   endtask

   task automatic test_full_push_pop();
      IO_write_en   = 1'b1;
      IO_write_sel  = 5'd18;
      IO_write_data = 15'h0555;
      out_ready     = 1'b1;
      IO_read_sel   = STAT;
      tick();
      idle();
      out_ready = 1'b0;
      #1;
      n_cmp++;
      if (IO_read_data !== 15'h0008 || overflow !== 1'b0) begin
         n_bad++;
         $display("FAIL full_push_pop_count: status=%h ovf=%b required 0008/0", IO_read_data,
                  overflow);
      end
      n_cmp++;
      if (out_chan !== 5'd17 || out_data !== 15'd2) begin
         n_bad++;
         $display("FAIL full_push_pop_head: chan=%0d data=%h required 17/0002", out_chan, out_data);
      end
   endtask

   task automatic test_peripheral();
      drain();
      in_valid    = 1'b1;
      in_chan     = 5'd3;
      in_data     = 15'h1ABC;
      IO_read_sel = 5'd3;
      #1;
      n_cmp++;
      if (IO_read_data !== 15'h1ABC) begin
         n_bad++;
         $display("FAIL periph_bypass: got %h required 1abc", IO_read_data);
      end
      tick();
      in_chan     = 5'd20;
      in_data     = 15'h7FFF;
      IO_read_sel = 5'd3;
      #1;
      n_cmp++;
      if (IO_read_data !== 15'h1ABC) begin
         n_bad++;
         $display("FAIL periph_stored: got %h required 1abc", IO_read_data);
      end
      IO_read_sel = 5'd20;
      #1;
      n_cmp++;
      if (IO_read_data !== 15'o12345) begin
         n_bad++;
         $display("FAIL periph_illegal_bypass: got %o required 12345", IO_read_data);
      end
      tick();
      idle();
      #1;
      n_cmp++;
      if (IO_read_data !== 15'o12345) begin
         n_bad++;
         $display("FAIL periph_illegal_ignored: got %o required 12345", IO_read_data);
      end
      // Both sources hit ch1 in the same cycle: the core must win.
      IO_write_en   = 1'b1;
      IO_write_sel  = 5'd1;
      IO_write_data = 15'h1111;
      in_valid      = 1'b1;
      in_chan       = 5'd1;
      in_data       = 15'h2222;
      IO_read_sel   = 5'd1;
      #1;
      n_cmp++;
      if (IO_read_data !== 15'h1111) begin
         n_bad++;
         $display("FAIL overlap_bypass: got %h required 1111", IO_read_data);
      end
      tick();
      idle();
      #1;
      n_cmp++;
      if (IO_read_data !== 15'h1111 || out_valid !== 1'b1 || out_chan !== 5'd1 ||
          out_data !== 15'h1111) begin
         n_bad++;
         $display("FAIL overlap_result: read=%h valid=%b chan=%0d data=%h required 1111/1/1/1111",
                  IO_read_data, out_valid, out_chan, out_data);
      end
   endtask

   task automatic test_parity();
      logic exp1;
      logic exp0;
`ifdef IO_CHAN_PARITY_EN
      exp1 = 1'b0;
      exp0 = 1'b1;
`else
      exp1 = 1'b0;
      exp0 = 1'b0;
`endif
      drain();
      IO_write_en   = 1'b1;
      IO_write_sel  = 5'd1;
      IO_write_data = 15'h0000;
      tick();
      idle();
      #1;
      n_cmp++;
      if (out_parity !== exp1 || out_chan !== 5'd1) begin
         n_bad++;
         $display("FAIL parity_ch1: par=%b chan=%0d required %b/1", out_parity, out_chan, exp1);
      end
      // Push and pop together at count 1: the new entry becomes head.
      IO_write_en   = 1'b1;
      IO_write_sel  = 5'd0;
      IO_write_data = 15'h0000;
      out_ready     = 1'b1;
      tick();
      idle();
      out_ready = 1'b0;
      #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_chan !== 5'd0 || out_parity !== exp0) begin
         n_bad++;
         $display("FAIL parity_ch0: valid=%b chan=%0d par=%b required 1/0/%b", out_valid,
                  out_chan, out_parity, exp0);
      end
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 3; k++) begin
         IO_write_en   = 1'b1;
         IO_write_sel  = 5'd16;
         IO_write_data = 15'h0100 + 15'(k);
         tick();
      end
      idle();
      out_ready = 1'b0;
      reset     = 1'b1;
      tick();
      reset = 1'b0;
      IO_read_sel = 5'd16;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || IO_read_data !== 15'h0000) begin
         n_bad++;
         $display("FAIL reset_mid: valid=%b ch16=%h required 0/0000", out_valid, IO_read_data);
      end
   endtask

   task automatic test_random();
      int ready_pct;
      for (int n = 0; n < 800; n++) begin
         ready_pct     = ((n / 60) % 2 == 0) ? 15 : 85;
         reset         = ($urandom_range(0, 199) == 0);
         IO_write_en   = ($urandom_range(0, 99) < 60);
         IO_write_sel  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(16, 31));
         IO_write_data = 15'($urandom);
         in_valid      = ($urandom_range(0, 99) < 50);
         in_chan       = ($urandom_range(0, 3) == 0) ? IO_write_sel : 5'($urandom);
         in_data       = 15'($urandom);
         out_ready     = ($urandom_range(0, 99) < ready_pct);
         case ($urandom_range(0, 3))
            0: IO_read_sel = IO_write_sel;
            1: IO_read_sel = in_chan;
            2: IO_read_sel = STAT;
            default: IO_read_sel = 5'($urandom);
         endcase
         #1;
         n_cmp++;
         if (IO_read_data !== exp_read()) begin
            n_bad++;
            $display("FAIL rand_read cyc%0d ch%0d: got %h required %h", n, IO_read_sel,
                     IO_read_data, exp_read());
         end
         n_cmp++;
         if (out_valid !== (m_q.size() > 0) || overflow !== m_ovf) begin
            n_bad++;
            $display("FAIL rand_flags cyc%0d: valid=%b ovf=%b required %b/%b", n, out_valid,
                     overflow, m_q.size() > 0, m_ovf);
         end
         if (m_q.size() > 0) begin
            n_cmp++;
            if ({out_chan, out_data} !== m_q[0]) begin
               n_bad++;
               $display("FAIL rand_head cyc%0d: got %h required %h", n, {out_chan, out_data},
                        m_q[0]);
            end
         end
         n_cmp++;
         if (out_parity !== exp_parity()) begin
            n_bad++;
            $display("FAIL rand_parity cyc%0d: got %b required %b", n, out_parity, exp_parity());
         end
         tick();
      end
      reset = 1'b0;
      idle();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_bypass();
      test_overflow();
      test_full_push_pop();
      test_peripheral();
      test_parity();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
